// File: rtl/vec_pkg.sv
// Shared constants and state encoding for the vector load/store sequencer.
//   ELEMS  : elements per vector register (transfer count per command)
//   WIDTH  : element / memory word width
//   AWIDTH : memory address width
//   RWIDTH : vector register index width
//   CWIDTH : element counter width
package vec_pkg;

  localparam int ELEMS  = 16;
  localparam int WIDTH  = 16;
  localparam int AWIDTH = 16;
  localparam int RWIDTH = 3;
  localparam int CWIDTH = $clog2(ELEMS);

  localparam logic [CWIDTH-1:0] CNT_ZERO   = {CWIDTH{1'b0}};
  localparam logic [CWIDTH-1:0] CNT_ONE    = {{(CWIDTH-1){1'b0}}, 1'b1};
  localparam logic [CWIDTH-1:0] CNT_LAST   = CWIDTH'(ELEMS - 1);
  localparam logic [CWIDTH-1:0] CNT_PENULT = CWIDTH'(ELEMS - 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_PRIME = 3'd1,
    LD_XFER  = 3'd2,
    ST_XFER  = 3'd3,
    ST_DRAIN = 3'd4,
    DONE     = 3'd5
  } ldst_state_t;

endpackage

// File: rtl/vec_addr_gen.sv
// Strided memory address generator.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   load       : capture base and stride; addr becomes base next cycle
//   step       : advance addr by the captured stride (wraps mod 2^AWIDTH)
//   base       : first address of the command
//   stride     : per-element address increment
//   addr       : current (registered) address
module vec_addr_gen
  import vec_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [AWIDTH-1:0] base,
  input  logic [AWIDTH-1:0] stride,
  output logic [AWIDTH-1:0] addr
);

  logic [AWIDTH-1:0] addr_r;
  logic [AWIDTH-1:0] stride_r;

  // Address and stride registers; load has priority over step.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_r   <= {AWIDTH{1'b0}};
      stride_r <= {AWIDTH{1'b0}};
    end else if (load) begin
      addr_r   <= base;
      stride_r <= stride;
    end else if (step) begin
      addr_r   <= addr_r + stride_r;
    end else begin
      addr_r   <= addr_r;
    end
  end

  assign addr = addr_r;

endmodule

// File: rtl/vec_ldst_seq.sv
// Vector load/store sequencer between data memory and the serial port of the
// vector register file. A load streams ELEMS memory words into one vector
// register; a store streams one vector register out to memory.
// Ports:
//   Clk, Rst_n          clock, asynchronous active-low reset
//   Start, IsStore      command strobe (accepted only in IDLE) and direction
//   VRegSel, BaseAddr   vector register and first memory address of the command
//   Stride              address increment (present only with VEC_LDST_STRIDE_EN)
//   Busy, Done          command in progress / one-cycle completion pulse
//   Addr, RD_s, WR_s    vector register file serial control
//   DataIn_s, DataOut_s vector register file serial write / read data
//   MemAddr, MemRd, MemWr, MemWrData, MemRdData   data memory port
// Configuration: define VEC_LDST_STRIDE_EN to add the Stride port; otherwise
// the stride is fixed at 1.
module vec_ldst_seq
  import vec_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Start,
  input  logic              IsStore,
  input  logic [RWIDTH-1:0] VRegSel,
  input  logic [AWIDTH-1:0] BaseAddr,
`ifdef VEC_LDST_STRIDE_EN
  input  logic [AWIDTH-1:0] Stride,
`endif
  output logic              Busy,
  output logic              Done,
  output logic [RWIDTH-1:0] Addr,
  output logic              RD_s,
  output logic              WR_s,
  output logic [WIDTH-1:0]  DataIn_s,
  input  logic [WIDTH-1:0]  DataOut_s,
  output logic [AWIDTH-1:0] MemAddr,
  output logic              MemRd,
  output logic              MemWr,
  output logic [WIDTH-1:0]  MemWrData,
  input  logic [WIDTH-1:0]  MemRdData
);

  ldst_state_t       state_r, next_state_s;
  logic [CWIDTH-1:0] cnt_r, nxt_cnt_s;
  logic [RWIDTH-1:0] vreg_r;
  logic              busy_r, done_r, rd_r, wr_r, memrd_r, memwr_r;
  logic              nxt_busy_s, nxt_done_s, nxt_rd_s, nxt_wr_s, nxt_memrd_s, nxt_memwr_s;
  logic              load_s, step_s;
  logic [AWIDTH-1:0] stride_s;
  logic [AWIDTH-1:0] mem_addr_s;

`ifdef VEC_LDST_STRIDE_EN
  assign stride_s = Stride;
`else
  assign stride_s = {{(AWIDTH-1){1'b0}}, 1'b1};
`endif

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state plus next value of every registered output. Control outputs are
  // computed one cycle ahead so that they are flops, not state decode.
  always_comb begin
    next_state_s = state_r;
    nxt_cnt_s    = cnt_r;
    nxt_busy_s   = 1'b0;
    nxt_done_s   = 1'b0;
    nxt_rd_s     = 1'b0;
    nxt_wr_s     = 1'b0;
    nxt_memrd_s  = 1'b0;
    nxt_memwr_s  = 1'b0;
    load_s       = 1'b0;
    step_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start) begin
          load_s     = 1'b1;
          nxt_busy_s = 1'b1;
          nxt_cnt_s  = CNT_ZERO;
          if (IsStore) begin
            next_state_s = ST_XFER;
            nxt_rd_s     = 1'b1;
          end else begin
            next_state_s = LD_PRIME;
            nxt_memrd_s  = 1'b1;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      LD_PRIME: begin
        // First read is in flight; its data arrives with the first write.
        step_s       = 1'b1;
        next_state_s = LD_XFER;
        nxt_cnt_s    = CNT_ZERO;
        nxt_busy_s   = 1'b1;
        nxt_wr_s     = 1'b1;
        nxt_memrd_s  = 1'b1;
      end
      LD_XFER: begin
        step_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          next_state_s = DONE;
          nxt_done_s   = 1'b1;
        end else begin
          next_state_s = LD_XFER;
          nxt_cnt_s    = cnt_r + CNT_ONE;
          nxt_busy_s   = 1'b1;
          nxt_wr_s     = 1'b1;
          // Prefetch runs one element ahead, so no read in the last element.
          nxt_memrd_s  = (cnt_r != CNT_PENULT);
        end
      end
      ST_XFER: begin
        // Memory writes trail register reads by one cycle, so the address
        // must not move until the first write is presented.
        step_s      = (cnt_r != CNT_ZERO);
        nxt_busy_s  = 1'b1;
        nxt_memwr_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          next_state_s = ST_DRAIN;
        end else begin
          next_state_s = ST_XFER;
          nxt_cnt_s    = cnt_r + CNT_ONE;
          nxt_rd_s     = 1'b1;
        end
      end
      ST_DRAIN: begin
        next_state_s = DONE;
        nxt_done_s   = 1'b1;
      end
      DONE: begin
        next_state_s = IDLE;
        nxt_cnt_s    = CNT_ZERO;
      end
      default: begin
        next_state_s = IDLE;
        nxt_cnt_s    = CNT_ZERO;
      end
    endcase
  end

  // Element counter and registered control outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      memrd_r <= 1'b0;
      memwr_r <= 1'b0;
    end else begin
      cnt_r   <= nxt_cnt_s;
      busy_r  <= nxt_busy_s;
      done_r  <= nxt_done_s;
      rd_r    <= nxt_rd_s;
      wr_r    <= nxt_wr_s;
      memrd_r <= nxt_memrd_s;
      memwr_r <= nxt_memwr_s;
    end
  end

  // Vector register index, held for the whole command.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      vreg_r <= {RWIDTH{1'b0}};
    end else if (load_s) begin
      vreg_r <= VRegSel;
    end else begin
      vreg_r <= vreg_r;
    end
  end

  vec_addr_gen u_addr_gen (
    .Clk    (Clk),
    .Rst_n  (Rst_n),
    .load   (load_s),
    .step   (step_s),
    .base   (BaseAddr),
    .stride (stride_s),
    .addr   (mem_addr_s)
  );

  assign Busy    = busy_r;
  assign Done    = done_r;
  assign RD_s    = rd_r;
  assign WR_s    = wr_r;
  assign MemRd   = memrd_r;
  assign MemWr   = memwr_r;
  assign Addr    = vreg_r;
  assign MemAddr = mem_addr_s;

  // Data moves straight through in the same cycle it is valid; gating with the
  // registered strobe keeps the buses at zero whenever no transfer is active.
  assign DataIn_s  = wr_r    ? MemRdData : {WIDTH{1'b0}};
  assign MemWrData = memwr_r ? DataOut_s : {WIDTH{1'b0}};

endmodule

// File: tb/tb_vec_ldst_seq.sv
// Self-checking bench for vec_ldst_seq: memory and vector register file models,
// a scoreboard of expected memory reads/writes, register writes and Done
// timing filled at command issue, and a monitor that checks DUT traffic.
module tb_vec_ldst_seq;
  import vec_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        IsStore = 1'b0;
  logic [2:0]  VRegSel = 3'd0;
  logic [15:0] BaseAddr = 16'h0000;
  logic [15:0] Stride = 16'h0001;
  logic [15:0] MemRdData = 16'h0000;
  logic [15:0] DataOut_s = 16'h0000;
  logic        Busy, Done, RD_s, WR_s, MemRd, MemWr;
  logic [2:0]  Addr;
  logic [15:0] DataIn_s, MemAddr, MemWrData;

  vec_ldst_seq dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .IsStore(IsStore),
    .VRegSel(VRegSel), .BaseAddr(BaseAddr),
`ifdef VEC_LDST_STRIDE_EN
    .Stride(Stride),
`endif
    .Busy(Busy), .Done(Done), .Addr(Addr), .RD_s(RD_s), .WR_s(WR_s),
    .DataIn_s(DataIn_s), .DataOut_s(DataOut_s), .MemAddr(MemAddr),
    .MemRd(MemRd), .MemWr(MemWr), .MemWrData(MemWrData), .MemRdData(MemRdData)
  );

  always #5 Clk = ~Clk;

  typedef struct packed { logic [15:0] a; logic [15:0] d; } mw_t;
  typedef struct packed { logic [2:0] r; logic [15:0] d; } vw_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [15:0] mem_m [0:65535];
  logic [15:0] vreg_m [0:7][0:15];
  logic [15:0] exp_rd_q [$];
  mw_t         exp_mw_q [$];
  vw_t         exp_vw_q [$];
  int          exp_done_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h required=no such event (cycle %0d)", name, act, cyc);
  endtask

  initial forever begin
    @(posedge Clk);
    cyc++;
  end

  // Environment: memory and register-file responders.
  logic wr_prev = 1'b0, rd_prev = 1'b0, rd_pend = 1'b0, mrd_pend = 1'b0;
  int widx = 0, ridx = 0;
  logic [15:0] mrd_addr = 16'h0000;
  logic [2:0]  rd_reg = 3'd0;
  initial forever begin
    @(negedge Clk);
    mrd_pend = MemRd;
    mrd_addr = MemAddr;
    if (MemWr) mem_m[MemAddr] = MemWrData;
    if (WR_s) begin
      widx = wr_prev ? widx + 1 : 0;
      if (widx < 16) vreg_m[Addr][widx] = DataIn_s;
    end
    wr_prev = WR_s;
    rd_pend = RD_s;
    if (RD_s) begin
      ridx = rd_prev ? ridx + 1 : 0;
      rd_reg = Addr;
    end
    rd_prev = RD_s;
    @(posedge Clk);
    #1;
    MemRdData = mrd_pend ? mem_m[mrd_addr] : 16'h0000;
    DataOut_s = (rd_pend && ridx < 16) ? vreg_m[rd_reg][ridx] : 16'h0000;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transfer.
  initial forever begin
    logic [15:0] ea;
    mw_t mw;
    vw_t vw;
    int  dc;
    @(negedge Clk);
    if (Rst_n) begin
      if (RD_s || WR_s) check("rd_wr_exclusive", {31'd0, RD_s & WR_s}, 32'd0);
      if (MemRd) begin
        check("memrd_memwr_exclusive", {31'd0, MemWr}, 32'd0);
        if (exp_rd_q.size() == 0) unexpected("memrd", {16'd0, MemAddr});
        else begin
          ea = exp_rd_q.pop_front();
          check("memrd_addr", {16'd0, MemAddr}, {16'd0, ea});
        end
      end
      if (MemWr) begin
        if (exp_mw_q.size() == 0) unexpected("memwr", {MemAddr, MemWrData});
        else begin
          mw = exp_mw_q.pop_front();
          check("memwr_addr", {16'd0, MemAddr}, {16'd0, mw.a});
          check("memwr_data", {16'd0, MemWrData}, {16'd0, mw.d});
        end
      end
      if (WR_s) begin
        if (exp_vw_q.size() == 0) unexpected("vreg_write", {13'd0, Addr, DataIn_s});
        else begin
          vw = exp_vw_q.pop_front();
          check("vreg_addr", {29'd0, Addr}, {29'd0, vw.r});
          check("vreg_data", {16'd0, DataIn_s}, {16'd0, vw.d});
        end
      end
      if (Done) begin
        done_cnt++;
        check("busy_low_at_done", {31'd0, Busy}, 32'd0);
        if (exp_done_q.size() == 0) unexpected("done_pulse", cyc);
        else begin
          dc = exp_done_q.pop_front();
          check("done_cycle", cyc, dc);
        end
      end
    end
  end

  // Issue one command; expectations come from the address/data rules directly.
  task automatic issue(input logic st, input logic [2:0] v, input logic [15:0] base,
                       input logic [15:0] stride);
    logic [15:0] a;
`ifndef VEC_LDST_STRIDE_EN
    stride = 16'h0001;
`endif
    @(posedge Clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      a = base + 16'(i) * stride;
      if (st) exp_mw_q.push_back('{a: a, d: vreg_m[v][i]});
      else begin
        exp_rd_q.push_back(a);
        exp_vw_q.push_back('{r: v, d: mem_m[a]});
      end
    end
    exp_done_q.push_back(cyc + 18);
    Start = 1'b1;
    IsStore = st;
    VRegSel = v;
    BaseAddr = base;
    Stride = stride;
    @(posedge Clk);
    #1;
    check("busy_after_start", {31'd0, Busy}, 32'd1);
  endtask

  // Bounded wait for the Done pulse, then scoreboard must be empty.
  task automatic finish_cmd(input int d0);
    for (int k = 0; k < 40; k++) begin
      @(posedge Clk);
      if (done_cnt != d0) break;
    end
    #1;
    Start = 1'b0;
    check("done_seen", done_cnt - d0, 32'd1);
    repeat (2) @(posedge Clk);
    #1;
    check("scoreboard_drained",
          exp_rd_q.size() + exp_mw_q.size() + exp_vw_q.size() + exp_done_q.size(), 32'd0);
  endtask

  task automatic run_cmd(input logic st, input logic [2:0] v, input logic [15:0] base,
                         input logic [15:0] stride);
    int d0;
    d0 = done_cnt;
    issue(st, v, base, stride);
    Start = 1'b0;
    finish_cmd(d0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int d0, seen;
    logic [15:0] st;
    for (int a = 0; a < 65536; a++) mem_m[a] = 16'($urandom);
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < 16; i++) vreg_m[r][i] = 16'($urandom);
    for (int i = 0; i < 16; i++) begin
      mem_m[16'h0100 + i] = 16'hA000 + 16'(i);
      vreg_m[5][i] = 16'h5000 + 16'(i);
    end

    repeat (3) @(posedge Clk);
    #1;
    check("reset_ctrl", {26'd0, Busy, Done, RD_s, WR_s, MemRd, MemWr}, 32'd0);
    check("reset_addr", {13'd0, Addr, MemAddr}, 32'd0);
    check("reset_data", {DataIn_s, MemWrData}, 32'd0);
    Rst_n = 1'b1;

    // Unit-stride load into vreg 2.
    run_cmd(1'b0, 3'd2, 16'h0100, 16'h0001);
    for (int i = 0; i < 16; i++) check("load_vreg2", {16'd0, vreg_m[2][i]}, 32'hA000 + i);

    // Store from vreg 5.
    run_cmd(1'b1, 3'd5, 16'h0040, 16'h0001);
    for (int i = 0; i < 16; i++) check("store_mem", {16'd0, mem_m[16'h0040 + i]}, 32'h5000 + i);

    // Address wrap past 0xFFFF.
    run_cmd(1'b0, 3'd1, 16'hFFF8, 16'h0001);

    // Start held high for the whole command: one command, one Done.
    d0 = done_cnt;
    issue(1'b0, 3'd6, 16'h0800, 16'h0001);
    finish_cmd(d0);
    check("held_start_one_done", done_cnt - d0, 32'd1);

    // Reset during load element 7.
    issue(1'b0, 3'd3, 16'h0300, 16'h0001);
    Start = 1'b0;
    seen = 0;
    for (int k = 0; k < 30 && seen < 8; k++) begin
      @(negedge Clk);
      if (WR_s) seen++;
    end
    #1;
    Rst_n = 1'b0;
    #1;
    check("midreset_ctrl", {26'd0, Busy, Done, RD_s, WR_s, MemRd, MemWr}, 32'd0);
    check("midreset_addr", {13'd0, Addr, MemAddr}, 32'd0);
    check("midreset_data", {DataIn_s, MemWrData}, 32'd0);
    exp_rd_q.delete();
    exp_mw_q.delete();
    exp_vw_q.delete();
    exp_done_q.delete();
    repeat (2) @(posedge Clk);
    #2;
    Rst_n = 1'b1;
    run_cmd(1'b0, 3'd3, 16'h0400, 16'h0001);

`ifdef VEC_LDST_STRIDE_EN
    run_cmd(1'b1, 3'd4, 16'h0000, 16'h0004);
    run_cmd(1'b1, 3'd7, 16'h0000, 16'h0000);
    check("stride0_last_wins", {16'd0, mem_m[16'h0000]}, {16'd0, vreg_m[7][15]});
`endif

    // Randomised commands.
    for (int n = 0; n < 12; n++) begin
      st = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 300));
      repeat ($urandom_range(0, 3)) @(posedge Clk);
      run_cmd(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom), st);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
